// File: rtl/decode_stage_if.sv
// Fetch/regfile/writeback/execute bundle for the RV32I decode stage.
// The slave modport is the decode stage; the master modport is its surroundings.
interface decode_stage_if;
  localparam int unsigned XLEN = 32;
  localparam int unsigned RAW  = 5;

  logic            flush_i;
  logic            if_valid_i;
  logic            if_ready_o;
  logic [XLEN-1:0] if_instr_i;
  logic [XLEN-1:0] if_pc_i;
  logic [RAW-1:0]  rs1_addr_o;
  logic [RAW-1:0]  rs2_addr_o;
  logic [XLEN-1:0] rs1_data_i;
  logic [XLEN-1:0] rs2_data_i;
  logic            wb_wr_en_i;
  logic [RAW-1:0]  wb_rd_addr_i;
  logic [XLEN-1:0] wb_wr_data_i;
  logic            ex_valid_o;
  logic            ex_ready_i;
  logic [XLEN-1:0] ex_pc_o;
  logic [XLEN-1:0] ex_rs1_data_o;
  logic [XLEN-1:0] ex_rs2_data_o;
  logic [XLEN-1:0] ex_imm_o;
  logic [RAW-1:0]  ex_rd_addr_o;
  logic [6:0]      ex_opcode_o;
  logic [2:0]      ex_funct3_o;
  logic            ex_funct7b5_o;
  logic            ex_reg_wr_o;
  logic            ex_illegal_o;

  modport slave (
    input  flush_i, if_valid_i, if_instr_i, if_pc_i, rs1_data_i, rs2_data_i,
           wb_wr_en_i, wb_rd_addr_i, wb_wr_data_i, ex_ready_i,
    output if_ready_o, rs1_addr_o, rs2_addr_o, ex_valid_o, ex_pc_o,
           ex_rs1_data_o, ex_rs2_data_o, ex_imm_o, ex_rd_addr_o, ex_opcode_o,
           ex_funct3_o, ex_funct7b5_o, ex_reg_wr_o, ex_illegal_o
  );

  modport master (
    output flush_i, if_valid_i, if_instr_i, if_pc_i, rs1_data_i, rs2_data_i,
           wb_wr_en_i, wb_rd_addr_i, wb_wr_data_i, ex_ready_i,
    input  if_ready_o, rs1_addr_o, rs2_addr_o, ex_valid_o, ex_pc_o,
           ex_rs1_data_o, ex_rs2_data_o, ex_imm_o, ex_rd_addr_o, ex_opcode_o,
           ex_funct3_o, ex_funct7b5_o, ex_reg_wr_o, ex_illegal_o
  );
endinterface

// File: rtl/decode_stage.sv
// RV32I decode stage: register-file read, immediate generation, one payload
// register toward execute with valid/ready handshake.
// Optional macro DECODE_WB_BYPASS_EN: forward a same-cycle writeback into the
// operands instead of stalling one cycle.
module decode_stage (
  input logic           clk_i,
  input logic           rst_i,
  decode_stage_if.slave bus
);
  localparam int unsigned XLEN = 32;
  localparam int unsigned RAW  = 5;

  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_MISC   = 7'b0001111;
  localparam logic [6:0] OPC_OPIMM  = 7'b0010011;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_OP     = 7'b0110011;
  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;
  localparam logic [6:0] OPC_SYSTEM = 7'b1110011;

  logic [XLEN-1:0] w_instr;
  logic [6:0]      w_opcode;
  logic [RAW-1:0]  w_rs1_addr;
  logic [RAW-1:0]  w_rs2_addr;
  logic [RAW-1:0]  w_rd_addr;
  logic            w_wb_hit1;
  logic            w_wb_hit2;
  logic            w_stall;
  logic [XLEN-1:0] w_rs1_val;
  logic [XLEN-1:0] w_rs2_val;
  logic            w_if_ready;
  logic            w_accept;
  logic [XLEN-1:0] w_imm;
  logic            w_writes_rd;
  logic            w_illegal;

  logic            r_ex_valid;
  logic [XLEN-1:0] r_pc;
  logic [XLEN-1:0] r_rs1;
  logic [XLEN-1:0] r_rs2;
  logic [XLEN-1:0] r_imm;
  logic [RAW-1:0]  r_rd;
  logic [6:0]      r_opcode;
  logic [2:0]      r_funct3;
  logic            r_funct7b5;
  logic            r_reg_wr;
  logic            r_illegal;

  assign w_instr    = bus.if_instr_i;
  assign w_opcode   = w_instr[6:0];
  assign w_rd_addr  = w_instr[11:7];
  assign w_rs1_addr = w_instr[19:15];
  assign w_rs2_addr = w_instr[24:20];

  assign bus.rs1_addr_o = w_rs1_addr;
  assign bus.rs2_addr_o = w_rs2_addr;

  // Writeback to a nonzero register that this instruction reads
  assign w_wb_hit1 = bus.wb_wr_en_i && (bus.wb_rd_addr_i != '0) && (bus.wb_rd_addr_i == w_rs1_addr);
  assign w_wb_hit2 = bus.wb_wr_en_i && (bus.wb_rd_addr_i != '0) && (bus.wb_rd_addr_i == w_rs2_addr);

`ifdef DECODE_WB_BYPASS_EN
  assign w_stall   = 1'b0;
  assign w_rs1_val = (w_rs1_addr == '0) ? '0 : (w_wb_hit1 ? bus.wb_wr_data_i : bus.rs1_data_i);
  assign w_rs2_val = (w_rs2_addr == '0) ? '0 : (w_wb_hit2 ? bus.wb_wr_data_i : bus.rs2_data_i);
`else
  logic w_unused_wb;
  assign w_unused_wb = ^bus.wb_wr_data_i;
  // Regfile read is not yet updated this cycle: wait one cycle for it
  assign w_stall   = w_wb_hit1 || w_wb_hit2;
  assign w_rs1_val = (w_rs1_addr == '0) ? '0 : bus.rs1_data_i;
  assign w_rs2_val = (w_rs2_addr == '0) ? '0 : bus.rs2_data_i;
`endif

  assign w_if_ready     = (!r_ex_valid || bus.ex_ready_i) && !w_stall && !bus.flush_i;
  assign w_accept       = bus.if_valid_i && w_if_ready;
  assign bus.if_ready_o = w_if_ready;

  // Immediate format, rd-write and legality by opcode
  always_comb begin
    w_imm       = '0;
    w_writes_rd = 1'b0;
    w_illegal   = 1'b0;
    case (w_opcode)
      OPC_LOAD, OPC_OPIMM, OPC_JALR: begin
        w_imm       = {{20{w_instr[31]}}, w_instr[31:20]};
        w_writes_rd = 1'b1;
      end
      OPC_SYSTEM: w_imm = {{20{w_instr[31]}}, w_instr[31:20]};
      OPC_STORE:  w_imm = {{20{w_instr[31]}}, w_instr[31:25], w_instr[11:7]};
      OPC_BRANCH: w_imm = {{19{w_instr[31]}}, w_instr[31], w_instr[7],
                           w_instr[30:25], w_instr[11:8], 1'b0};
      OPC_LUI, OPC_AUIPC: begin
        w_imm       = {w_instr[31:12], 12'h000};
        w_writes_rd = 1'b1;
      end
      OPC_JAL: begin
        w_imm       = {{11{w_instr[31]}}, w_instr[31], w_instr[19:12],
                       w_instr[20], w_instr[30:21], 1'b0};
        w_writes_rd = 1'b1;
      end
      OPC_OP:   w_writes_rd = 1'b1;
      OPC_MISC: w_writes_rd = 1'b0;
      default:  w_illegal   = 1'b1;
    endcase
  end

  // Execute-side valid: flush wins, then accept, then drain on ready
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_ex_valid <= 1'b0;
    end else if (bus.flush_i) begin
      r_ex_valid <= 1'b0;
    end else if (w_accept) begin
      r_ex_valid <= 1'b1;
    end else if (bus.ex_ready_i) begin
      r_ex_valid <= 1'b0;
    end
  end

  // Payload registers load only on accept, so they hold during back-pressure
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_pc       <= '0;
      r_rs1      <= '0;
      r_rs2      <= '0;
      r_imm      <= '0;
      r_rd       <= '0;
      r_opcode   <= '0;
      r_funct3   <= '0;
      r_funct7b5 <= 1'b0;
      r_reg_wr   <= 1'b0;
      r_illegal  <= 1'b0;
    end else if (w_accept) begin
      r_pc       <= bus.if_pc_i;
      r_rs1      <= w_rs1_val;
      r_rs2      <= w_rs2_val;
      r_imm      <= w_imm;
      r_rd       <= w_rd_addr;
      r_opcode   <= w_opcode;
      r_funct3   <= w_instr[14:12];
      r_funct7b5 <= w_instr[30];
      r_reg_wr   <= w_writes_rd && (w_rd_addr != '0);
      r_illegal  <= w_illegal;
    end
  end

  assign bus.ex_valid_o    = r_ex_valid;
  assign bus.ex_pc_o       = r_pc;
  assign bus.ex_rs1_data_o = r_rs1;
  assign bus.ex_rs2_data_o = r_rs2;
  assign bus.ex_imm_o      = r_imm;
  assign bus.ex_rd_addr_o  = r_rd;
  assign bus.ex_opcode_o   = r_opcode;
  assign bus.ex_funct3_o   = r_funct3;
  assign bus.ex_funct7b5_o = r_funct7b5;
  assign bus.ex_reg_wr_o   = r_reg_wr;
  assign bus.ex_illegal_o  = r_illegal;
endmodule

// File: doc/decode_stage.md
DECODE_STAGE -- requirements
Module: decode_stage

Interface
REQ-001 The block SHALL have no parameters; datapath width is fixed at 32 bits, RV32I.
REQ-002 The block SHALL have one clock; reset is asynchronous and active-high. Ports:
- clk_i  in  1  clock, rising edge.
- rst_i  in  1  asynchronous active-high reset.
- flush_i  in  1  discard the held and incoming instruction.
- if_valid_i  in  1  fetch offers an instruction.
- if_ready_o  out  1  decode accepts it this cycle.
- if_instr_i  in  32  instruction word.
- if_pc_i  in  32  instruction PC.
- rs1_addr_o  out  5  register-file read address 1, from if_instr_i[19:15].
- rs2_addr_o  out  5  register-file read address 2, from if_instr_i[24:20].
- rs1_data_i  in  32  register-file read data 1 (combinational read).
- rs2_data_i  in  32  register-file read data 2.
- wb_wr_en_i  in  1  writeback write enable, same cycle as the register-file write.
- wb_rd_addr_i  in  5  writeback destination register.
- wb_wr_data_i  in  32  writeback data.
- ex_valid_o  out  1  execute payload valid.
- ex_ready_i  in  1  execute accepts the payload.
- ex_pc_o  out  32  PC.
- ex_rs1_data_o  out  32  operand 1.
- ex_rs2_data_o  out  32  operand 2.
- ex_imm_o  out  32  sign-extended immediate.
- ex_rd_addr_o  out  5  destination register.
- ex_opcode_o  out  7  opcode.
- ex_funct3_o  out  3  funct3.
- ex_funct7b5_o  out  1  instr[30].
- ex_reg_wr_o  out  1  instruction writes rd, and rd is not x0.
- ex_illegal_o  out  1  opcode is not RV32I.

Function
REQ-003 rs1_addr_o and rs2_addr_o SHALL be purely combinational from if_instr_i, regardless of if_valid_i.
REQ-004 if_ready_o SHALL be (~ex_valid_o | ex_ready_i) & ~stall & ~flush_i.
REQ-005 An instruction SHALL be accepted when if_valid_i & if_ready_o; the payload registers load on that edge, giving 1-cycle latency.
REQ-006 ex_valid_o SHALL:
- set on accept;
- clear when ex_ready_i is high and nothing is accepted;
- otherwise hold.
REQ-007 While ex_valid_o & ~ex_ready_i, all ex_* payload outputs SHALL hold stable.
REQ-008 The immediate SHALL follow the opcode type:
- I for 0000011, 0010011, 1100111, 1110011;
- S for 0100011;
- B for 1100011;
- U for 0110111, 0010111;
- J for 1101111;
- 0 for all other opcodes.
REQ-009 ex_reg_wr_o SHALL be 1 for LUI, AUIPC, JAL, JALR, LOAD, OP-IMM and OP when rd is not 0, and 0 otherwise.
REQ-010 Any opcode outside REQ-008, except OP (0110011) and MISC-MEM (0001111), SHALL give ex_illegal_o=1 and ex_reg_wr_o=0.
REQ-011 A source address of 0 SHALL yield operand 0, regardless of register-file data or writeback.
REQ-012 flush_i SHALL take priority over everything:
- ex_valid_o is 0 on the next edge;
- no accept occurs in the flush cycle;
- payload registers may hold stale values.
REQ-013 There is no internal state beyond the payload registers and ex_valid_o; a back-to-back accept every cycle SHALL be possible when ex_ready_i=1.

Reset
REQ-014 While rst_i is high, ex_valid_o SHALL be 0 immediately (asynchronously).
REQ-015 While rst_i is high, all ex_* payload outputs SHALL be 0.
REQ-016 A reset asserted mid-stall SHALL drop the held instruction; the first accept SHALL be on the first rising edge after rst_i falls.

Configuration
REQ-017 The macro DECODE_WB_BYPASS_EN SHALL select how a same-cycle writeback hazard is handled.
- Defined: when wb_wr_en_i is high and wb_rd_addr_i is not 0 and equals a source address, that operand SHALL take wb_wr_data_i; stall is always 0.
- Undefined: the same match SHALL assert stall for exactly that cycle, holding if_ready_o low; the instruction is accepted the next cycle with the updated register-file data.

Verification
REQ-018 The bench SHALL cover these scenarios:
- ADDI x5,x1,-4 (0xFFC08293), x1=7 in the register file, ex_ready_i=1 -> next cycle ex_valid_o=1, ex_imm_o=0xFFFFFFFC, ex_rs1_data_o=7, ex_rd_addr_o=5, ex_reg_wr_o=1.
- ex_ready_i=0 for 3 cycles with a second instruction offered -> if_ready_o=0 and the payload is unchanged for 3 cycles; the second instruction is accepted in the cycle ex_ready_i returns to 1.
- ADD x3,x2,x2 offered while the writeback writes x2=0x55 -> with the macro, operands are 0x55 with no stall; without it, if_ready_o=0 for one cycle and the operands are 0x55 the next cycle.
- BEQ with offset -8 -> ex_imm_o=0xFFFFFFF8 and ex_reg_wr_o=0; opcode 0x7F -> ex_illegal_o=1.
- flush_i during a stall -> ex_valid_o=0 on the next edge and no accept in the flush cycle.
- rst_i asserted between edges -> ex_valid_o falls without waiting for a clock edge.
